// File: rtl/rv_enc_pkg.sv
// Shared RV32I encode/decode definitions: instruction formats, field positions and the NOP word.
package rv_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_S  = 3'd2,
        FMT_SB = 3'd3,
        FMT_U  = 3'd4,
        FMT_UJ = 3'd5
    } fmt_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNC3_LSB  = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNC7_LSB  = 25;

    // Immediate widths carried by the short (I/S/SB) and long (U/UJ) formats.
    localparam int IMM_SHORT_W = 12;
    localparam int IMM_LONG_W  = 20;

    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } enc_result_t;

endpackage

// File: rtl/enc_fifo.sv
// Count-based output FIFO holding {err, addr, instr} entries for the instruction encoder.
module enc_fifo #(
    parameter int               DEPTH     = 4,
    parameter int               ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              push_err_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [31:0]       push_instr_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic              head_err_o,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [31:0]       head_instr_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 1 + ADDR_W + 32;
    localparam logic [ENTRY_W-1:0] RST_ENTRY = {1'b0, BASE_ADDR, 32'h0};

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign {head_err_o, head_addr_o, head_instr_o} = mem_q[rd_ptr_q];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = {push_err_i, push_addr_i, push_instr_i};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: storage is reset too, so the head outputs show the defined idle word after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RST_ENTRY;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_encode_unit.sv
// Packs RV32I fields into instruction words and buffers them, address-tagged, for the imem loader.
module instr_encode_unit
    import rv_enc_pkg::*;
#(
    parameter int               DEPTH     = 4,
    parameter int               ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              ENCrst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        fmt_i,
    input  logic [6:0]        opcode_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        func3_i,
    input  logic [6:0]        func7_i,
    input  logic [31:0]       immed_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              err_o,
    output logic [7:0]        err_cnt_o
);

    function automatic enc_result_t encode_beat(
        input fmt_e        fmt,
        input logic [6:0]  opcode,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  func3,
        input logic [6:0]  func7,
        input logic [31:0] immed
    );
        enc_result_t res;
        logic [31:0] w;
        logic        bad;
        w   = '0;
        bad = 1'b0;
        w[OPCODE_LSB +: 7] = opcode;
        case (fmt)
            FMT_R: begin
                w[FUNC7_LSB +: 7] = func7;
                w[RS2_LSB +: 5]   = rs2;
                w[RS1_LSB +: 5]   = rs1;
                w[FUNC3_LSB +: 3] = func3;
                w[RD_LSB +: 5]    = rd;
            end
            FMT_I: begin
                w[31:20]          = immed[11:0];
                w[RS1_LSB +: 5]   = rs1;
                w[FUNC3_LSB +: 3] = func3;
                w[RD_LSB +: 5]    = rd;
                bad               = |immed[31:IMM_SHORT_W];
            end
            FMT_S: begin
                w[31:25]          = immed[11:5];
                w[11:7]           = immed[4:0];
                w[RS2_LSB +: 5]   = rs2;
                w[RS1_LSB +: 5]   = rs1;
                w[FUNC3_LSB +: 3] = func3;
                bad               = |immed[31:IMM_SHORT_W];
            end
            FMT_SB: begin
                w[31]             = immed[11];
                w[7]              = immed[10];
                w[30:25]          = immed[9:4];
                w[11:8]           = immed[3:0];
                w[RS2_LSB +: 5]   = rs2;
                w[RS1_LSB +: 5]   = rs1;
                w[FUNC3_LSB +: 3] = func3;
                bad               = |immed[31:IMM_SHORT_W];
            end
            FMT_U: begin
                w[31:12]       = immed[19:0];
                w[RD_LSB +: 5] = rd;
                bad            = |immed[31:IMM_LONG_W];
            end
            FMT_UJ: begin
                w[31]          = immed[19];
                w[19:12]       = immed[18:11];
                w[20]          = immed[10];
                w[30:21]       = immed[9:0];
                w[RD_LSB +: 5] = rd;
                bad            = |immed[31:IMM_LONG_W];
            end
            default: bad = 1'b1;
        endcase
        if (opcode[1:0] != 2'b11) begin
            bad = 1'b1;
        end
        res.err   = bad;
        res.instr = bad ? NOP_INSTR : w;
        return res;
    endfunction

    enc_result_t       enc;
    logic              fifo_full, fifo_empty, push;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    assign enc = encode_beat(fmt_e'(fmt_i), opcode_i, rd_i, rs1_i, rs2_i,
                             func3_i, func7_i, immed_i);

    // Ready depends only on the registered fill level, never on out_ready_i.
    assign in_ready_o  = !fifo_full;
    assign push        = in_valid_i && !fifo_full;
    assign out_valid_o = !fifo_empty;
    assign err_cnt_o   = err_cnt_q;

    always_comb begin
        addr_d    = addr_q;
        err_cnt_d = err_cnt_q;
        if (push) begin
            addr_d = addr_q + ADDR_W'(4);
            if (enc.err && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (ENCrst_i) begin
            addr_q    <= BASE_ADDR;
            err_cnt_q <= '0;
        end else begin
            addr_q    <= addr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    enc_fifo #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (ENCrst_i),
        .push_i       (push),
        .push_err_i   (enc.err),
        .push_addr_i  (addr_q),
        .push_instr_i (enc.instr),
        .pop_i        (out_ready_i),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .head_err_o   (err_o),
        .head_addr_o  (addr_o),
        .head_instr_o (instr_o)
    );

endmodule

// File: tb/tb_instr_encode_unit.sv
// Self-checking bench: vector table, hand-written flow-control sequences and a randomized model run.
module tb_instr_encode_unit;
    import rv_enc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, in_valid_w, out_ready_w;
    logic [2:0]  fmt;
    logic [6:0]  opcode, func7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  func3;
    logic [31:0] immed;

    logic        in_ready, out_valid, err;
    logic [31:0] instr, addr;
    logic [7:0]  err_cnt;

    logic        in_ready_w, out_valid_w, err_w;
    logic [31:0] instr_w;
    logic [3:0]  addr_w;
    logic [7:0]  err_cnt_w;

    always #5 clk = ~clk;

    instr_encode_unit dut (
        .clk_i(clk), .ENCrst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .fmt_i(fmt), .opcode_i(opcode), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
        .func3_i(func3), .func7_i(func7), .immed_i(immed),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .instr_o(instr),
        .addr_o(addr), .err_o(err), .err_cnt_o(err_cnt)
    );

    instr_encode_unit #(.DEPTH(4), .ADDR_W(4), .BASE_ADDR(4'd12)) dut_w (
        .clk_i(clk), .ENCrst_i(rst), .in_valid_i(in_valid_w), .in_ready_o(in_ready_w),
        .fmt_i(fmt), .opcode_i(opcode), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
        .func3_i(func3), .func7_i(func7), .immed_i(immed),
        .out_valid_o(out_valid_w), .out_ready_i(out_ready_w), .instr_o(instr_w),
        .addr_o(addr_w), .err_o(err_w), .err_cnt_o(err_cnt_w)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder built from the field-placement rules with shifts and masks.
    function automatic logic [32:0] ref_encode(input int unsigned f, input int unsigned op,
                                               input int unsigned rdv, input int unsigned r1,
                                               input int unsigned r2, input int unsigned f3,
                                               input int unsigned f7, input int unsigned imm);
        int unsigned w;
        bit bad;
        bad = 0;
        case (f)
            0: w = (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (rdv << 7);
            1: begin w = ((imm % 4096) << 20) | (r1 << 15) | (f3 << 12) | (rdv << 7); bad = imm >= 4096; end
            2: begin
                w = (((imm >> 5) & 127) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | ((imm & 31) << 7);
                bad = imm >= 4096;
            end
            3: begin
                w = (((imm >> 11) & 1) << 31) | (((imm >> 4) & 63) << 25) | (r2 << 20) | (r1 << 15)
                  | (f3 << 12) | ((imm & 15) << 8) | (((imm >> 10) & 1) << 7);
                bad = imm >= 4096;
            end
            4: begin w = ((imm % 1048576) << 12) | (rdv << 7); bad = imm >= 1048576; end
            5: begin
                w = (((imm >> 19) & 1) << 31) | ((imm & 1023) << 21) | (((imm >> 10) & 1) << 20)
                  | (((imm >> 11) & 255) << 12) | (rdv << 7);
                bad = imm >= 1048576;
            end
            default: begin w = 0; bad = 1; end
        endcase
        w = w | op;
        if ((op % 4) != 3) bad = 1;
        if (bad) w = 32'h13;
        return {bad, w};
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_addr;
    int          m_errcnt;
    bit          last_acc;

    task automatic clear_model();
        q.delete();
        m_addr   = 32'd0;
        m_errcnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; in_valid_w = 1'b0; out_ready_w = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
    endtask

    // One cycle on the main instance: check outputs against the model, then advance one edge.
    task automatic step(input logic v, input logic r);
        bit          acc, pop;
        logic [32:0] enc;
        exp_t        e;
        in_valid  = v;
        out_ready = r;
        check("in_ready", in_ready, q.size() < 4);
        check("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("head_instr", instr, q[0].instr);
            check("head_addr", addr, q[0].addr);
            check("head_err", err, q[0].err);
        end
        check("err_cnt", err_cnt, m_errcnt);
        acc = v && (q.size() < 4);
        pop = r && (q.size() != 0);
        enc = ref_encode(fmt, opcode, rd, rs1, rs2, func3, func7, immed);
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (acc) begin
            e.instr = enc[31:0];
            e.addr  = m_addr;
            e.err   = enc[32];
            q.push_back(e);
            m_addr = m_addr + 32'd4;
            if (enc[32] && m_errcnt < 255) m_errcnt++;
        end
        last_acc = acc;
    endtask

    task automatic rand_beat(input bit legal);
        int unsigned r;
        logic [6:0]  op;
        r  = $urandom_range(0, 9);
        fmt = (!legal && r == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
        op = 7'($urandom) | 7'h03;
        if (!legal && r == 1) op[1:0] = 2'b10;
        opcode = op;
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        func3 = 3'($urandom); func7 = 7'($urandom);
        immed = $urandom;
        if (legal || r > 2) begin
            immed = immed & ((fmt == FMT_U || fmt == FMT_UJ) ? 32'hF_FFFF : 32'hFFF);
        end
    endtask

    task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                              input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; func3 = f3; func7 = f7; immed = imm;
    endtask

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    initial begin
        vecs[0]  = '{FMT_R,  7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0,        32'h002081B3, 1'b0};
        vecs[1]  = '{FMT_I,  7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h7FF,      32'h7FF00293, 1'b0};
        vecs[2]  = '{FMT_I,  7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1000,     32'h00000013, 1'b1};
        vecs[3]  = '{FMT_SB, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h801,      32'h80208163, 1'b0};
        vecs[4]  = '{FMT_S,  7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'h8,        32'h0020A423, 1'b0};
        vecs[5]  = '{FMT_S,  7'h23, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFE0,      32'hFE000023, 1'b0};
        vecs[6]  = '{FMT_U,  7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345,    32'h123450B7, 1'b0};
        vecs[7]  = '{FMT_UJ, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF,    32'hFFFFF0EF, 1'b0};
        vecs[8]  = '{FMT_UJ, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h400,      32'h0010006F, 1'b0};
        vecs[9]  = '{FMT_R,  7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hFFFFFFFF, 32'h403100B3, 1'b0};
        vecs[10] = '{3'd7,   7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'h0,        32'h00000013, 1'b1};
        vecs[11] = '{FMT_I,  7'h12, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1,        32'h00000013, 1'b1};
        vecs[12] = '{FMT_U,  7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h100000,   32'h00000013, 1'b1};
        vecs[13] = '{FMT_SB, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h1000,     32'h00000013, 1'b1};
        vecs[14] = '{FMT_SB, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h7FE,      32'h7E000EE3, 1'b0};

        set_fields(3'd0, 7'h33, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        last_acc = 0;
        do_reset();

        // Reset state of both instances.
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_err", err, 1'b0);
        check("rst_err_cnt", err_cnt, 8'h0);
        check("rst_addr_w", addr_w, 4'd12);
        check("rst_in_ready_w", in_ready_w, 1'b1);

        // Vector table: one beat each, visible the cycle after acceptance, then popped.
        for (int i = 0; i < NV; i++) begin
            set_fields(vecs[i].fmt, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                       vecs[i].f3, vecs[i].f7, vecs[i].imm);
            step(1'b1, 1'b0);
            check($sformatf("vec%0d_valid", i), out_valid, 1'b1);
            check($sformatf("vec%0d_instr", i), instr, vecs[i].exp_instr);
            check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
            check($sformatf("vec%0d_addr", i), addr, 32'(4 * i));
            step(1'b0, 1'b1);
        end
        check("table_err_cnt", err_cnt, 8'd5);

        // Fill to full with the consumer stalled, then drain while the fifth beat waits.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            rand_beat(1'b1);
            step(1'b1, 1'b0);
        end
        check("full_in_ready", in_ready, 1'b0);
        rand_beat(1'b1);
        step(1'b1, 1'b0);
        check("drain_addr0", addr, 32'd0);
        step(1'b1, 1'b1);
        check("drain_addr1", addr, 32'd4);
        step(1'b1, 1'b1);
        check("drain_addr2", addr, 32'd8);
        step(1'b0, 1'b1);
        check("drain_addr3", addr, 32'd12);
        step(1'b0, 1'b1);
        check("drain_addr4", addr, 32'd16);
        step(1'b0, 1'b1);
        check("drained_valid", out_valid, 1'b0);
        step(1'b0, 1'b1);

        // Narrow-address instance: wrap of the address tag and reset with entries queued.
        do_reset();
        set_fields(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        in_valid_w = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        in_valid_w = 1'b0;
        check("w_valid", out_valid_w, 1'b1);
        check("w_addr_first", addr_w, 4'd12);
        check("w_instr_first", instr_w, 32'h00100093);
        out_ready_w = 1'b1;
        @(posedge clk); #1;
        check("w_addr_wrap", addr_w, 4'd0);
        @(posedge clk); #1;
        out_ready_w = 1'b0;
        check("w_empty", out_valid_w, 1'b0);
        immed = 32'h1000;
        in_valid_w = 1'b1;
        @(posedge clk); #1;
        immed = 32'd1;
        repeat (2) begin @(posedge clk); #1; end
        in_valid_w = 1'b0;
        check("w_err_cnt", err_cnt_w, 8'd1);
        check("w_head_err", err_w, 1'b1);
        check("w_head_addr", addr_w, 4'd4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        check("w_rst_valid", out_valid_w, 1'b0);
        check("w_rst_ready", in_ready_w, 1'b1);
        check("w_rst_err_cnt", err_cnt_w, 8'd0);
        in_valid_w = 1'b1;
        @(posedge clk); #1;
        in_valid_w = 1'b0;
        check("w_post_rst_valid", out_valid_w, 1'b1);
        check("w_post_rst_addr", addr_w, 4'd12);
        check("w_post_rst_err", err_w, 1'b0);
        out_ready_w = 1'b1;
        @(posedge clk); #1;
        out_ready_w = 1'b0;

        // Error counter saturation.
        do_reset();
        set_fields(3'd7, 7'h33, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        for (int k = 0; k < 260; k++) begin
            step(1'b1, 1'b1);
        end
        check("err_cnt_sat", err_cnt, 8'd255);
        step(1'b0, 1'b1);

        // Randomized traffic against the model.
        do_reset();
        last_acc = 1;
        for (int k = 0; k < 800; k++) begin
            logic v, r;
            if (!in_valid || last_acc) rand_beat(1'b0);
            v = ($urandom_range(0, 3) != 0) || (in_valid && !last_acc);
            r = ($urandom_range(0, 2) != 0);
            step(v, r);
        end
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
